// File: rtl/seven_segment_counter_mux_pkg.sv
// Shared constants and helpers for the multiplexed BCD display counter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package seven_segment_counter_mux_pkg;

    localparam int                BCD_W   = 4;
    localparam int                SEG_W   = 7;
    localparam logic [BCD_W-1:0]  BCD_MAX = 4'd9;

    // Bits needed to hold values 0..n-1; never less than one so that
    // single-entry counters still get a legal declaration.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_segment_counter_mux_if.sv
// Control and display bundle between the pin wrapper (master) and the counter (slave).
// Latency: n/a (wiring only).
// Backpressure: none; display outputs are free-running, control inputs are level-sampled.
//   en, up_down, clear        : counter control, driven by master
//   segments, digit_sel       : multiplexed display drive, driven by slave
//   tick, wrap                : single-cycle event pulses, driven by slave
interface seven_segment_counter_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                                        en;
    logic                                        up_down;
    logic                                        clear;
    logic [seven_segment_counter_mux_pkg::SEG_W-1:0] segments;
    logic [NUM_DIGITS-1:0]                       digit_sel;
    logic                                        tick;
    logic                                        wrap;

    modport master (
        output en, up_down, clear,
        input  segments, digit_sel, tick, wrap
    );

    modport slave (
        input  en, up_down, clear,
        output segments, digit_sel, tick, wrap
    );
endinterface

// File: rtl/seg7.sv
// Shared BCD to 7-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: n/a.
//   bcd : 4-bit digit in      seg : segment pattern out (blank for 10..15)
module seg7
    import seven_segment_counter_mux_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/seven_segment_counter_mux_bcd_digit.sv
// One BCD digit register with ripple carry/borrow.
// Latency: value updates on the clock edge; carry_out is combinational from carry_in and state.
// Backpressure: none.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : synchronous zero (wins over stepping)
//   carry_in     : step this digit this cycle
//   inc / dec    : step direction (up / down)
//   val          : registered digit value, always 0..9
//   carry_out    : this digit rolled over (9->0 up, 0->9 down) and the next digit must step
module seven_segment_counter_mux_bcd_digit
    import seven_segment_counter_mux_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             carry_in,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] val,
    output logic             carry_out
);
    logic [BCD_W-1:0] val_q;
    logic [BCD_W-1:0] val_d;

    always_comb begin
        val_d     = val_q;
        carry_out = 1'b0;
        if (clr) begin
            val_d = '0;
        end else if (carry_in && inc) begin
            if (val_q >= BCD_MAX) begin
                val_d     = '0;
                carry_out = 1'b1;
            end else begin
                val_d = val_q + 4'd1;
            end
        end else if (carry_in && dec) begin
            if (val_q == '0) begin
                val_d     = BCD_MAX;
                carry_out = 1'b1;
            end else begin
                val_d = val_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;
endmodule

// File: rtl/seven_segment_counter_mux.sv
// N-digit up/down BCD counter driving a time-multiplexed 7-segment display.
// Latency: tick, wrap and new digits appear one cycle after the terminal prescaler edge, together.
// Backpressure: none; en=0 freezes counting, the display scan never stalls.
//   clk, reset_n : clock, synchronous active-low reset (overrides everything)
//   bus.slave    : en/up_down/clear in; segments/digit_sel/tick/wrap out
module seven_segment_counter_mux
    import seven_segment_counter_mux_pkg::*;
#(
    parameter int MAX_COUNT  = 'hFFFFF,
    parameter int NUM_DIGITS = 4,
    parameter int MUX_COUNT  = 'h3FF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    seven_segment_counter_mux_if.slave   bus
);
    localparam int PW = idx_width(MAX_COUNT + 1);
    localparam int SW = idx_width(MUX_COUNT + 1);
    localparam int IW = idx_width(NUM_DIGITS);

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          step;

    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        if (bus.clear) begin
            presc_d = '0;
        end else if (bus.en) begin
            if (presc_q == PW'(MAX_COUNT)) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        tick_d = step;
    end

    // ---------------- digit chain ----------------
    // Each digit gets its own carry nets so the ripple path is a chain of
    // distinct signals rather than a self-referencing vector.
    logic [BCD_W-1:0] digit_val [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic cin;
        logic cout;
        if (g == 0) begin : g_lsd
            assign cin = step;
        end else begin : g_upper
            assign cin = g_digit[g-1].cout;
        end
        seven_segment_counter_mux_bcd_digit u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (bus.clear),
            .carry_in  (cin),
            .inc       (bus.up_down),
            .dec       (~bus.up_down),
            .val       (digit_val[g]),
            .carry_out (cout)
        );
    end

    // A carry out of the top digit means every digit rolled over: 99..9 -> 0 or 0 -> 99..9.
    assign wrap_d = g_digit[NUM_DIGITS-1].cout;

    // ---------------- display scan ----------------
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SW'(1);
        scan_idx_d  = scan_idx_q;
        if (scan_cnt_q == SW'(MUX_COUNT)) begin
            scan_cnt_d = '0;
            if (scan_idx_q == IW'(NUM_DIGITS - 1)) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IW'(1);
            end
        end
        digit_sel_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_d == IW'(i)) begin
                digit_sel_d[i] = 1'b1;
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Segment mux reads registered digits and the registered index, so the
    // pattern always belongs to the digit currently strobed.
    logic [BCD_W-1:0] mux_digit;

    always_comb begin
        mux_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                mux_digit = digit_val[i];
            end
        end
    end

    seg7 u_seg7 (
        .bcd (mux_digit),
        .seg (bus.segments)
    );

    assign bus.digit_sel = digit_sel_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
module tb_seven_segment_counter_mux;
    localparam int A_MAX = 3, A_N = 2, A_MUX = 1;
    localparam int B_MAX = 1, B_N = 1, B_MUX = 0;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic en      = 1'b0;
    logic ud      = 1'b1;
    logic clr     = 1'b0;

    always #5 clk = ~clk;

    seven_segment_counter_mux_if #(.NUM_DIGITS(A_N)) ifa ();
    seven_segment_counter_mux_if #(.NUM_DIGITS(B_N)) ifb ();

    assign ifa.en = en;  assign ifa.up_down = ud;  assign ifa.clear = clr;
    assign ifb.en = en;  assign ifb.up_down = ud;  assign ifb.clear = clr;

    seven_segment_counter_mux #(.MAX_COUNT(A_MAX), .NUM_DIGITS(A_N), .MUX_COUNT(A_MUX)) u_dut_a (
        .clk (clk), .reset_n (rst_n), .bus (ifa)
    );
    seven_segment_counter_mux #(.MAX_COUNT(B_MAX), .NUM_DIGITS(B_N), .MUX_COUNT(B_MUX)) u_dut_b (
        .clk (clk), .reset_n (rst_n), .bus (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---- reference model: count as an integer, scan as elapsed cycles ----
    int m_cnt [2];
    int m_pre [2];
    int m_scan[2];
    bit m_tick[2];
    bit m_wrap[2];

    function automatic int p_max(input int k); return (k == 0) ? A_MAX : B_MAX; endfunction
    function automatic int p_n  (input int k); return (k == 0) ? A_N   : B_N;   endfunction
    function automatic int p_mux(input int k); return (k == 0) ? A_MUX : B_MUX; endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_edge();
        int m;
        for (int k = 0; k < 2; k++) begin
            m = pow10(p_n(k));
            if (!rst_n) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_scan[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
            end else begin
                m_scan[k] = (m_scan[k] + 1) % ((p_mux(k) + 1) * p_n(k));
                m_tick[k] = 0;
                m_wrap[k] = 0;
                if (clr) begin
                    m_cnt[k] = 0; m_pre[k] = 0;
                end else if (en) begin
                    if (m_pre[k] == p_max(k)) begin
                        m_pre[k]  = 0;
                        m_tick[k] = 1;
                        if (ud) begin
                            m_wrap[k] = (m_cnt[k] == m - 1);
                            m_cnt[k]  = (m_cnt[k] + 1) % m;
                        end else begin
                            m_wrap[k] = (m_cnt[k] == 0);
                            m_cnt[k]  = (m_cnt[k] + m - 1) % m;
                        end
                    end else begin
                        m_pre[k] = m_pre[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        int idx, dig;
        for (int k = 0; k < 2; k++) begin
            idx = m_scan[k] / (p_mux(k) + 1);
            dig = (m_cnt[k] / pow10(idx)) % 10;
            if (k == 0) begin
                chk("A.tick", 32'(ifa.tick), 32'(m_tick[0]));
                chk("A.wrap", 32'(ifa.wrap), 32'(m_wrap[0]));
                chk("A.digit_sel", 32'(ifa.digit_sel), 32'(1) << idx);
                chk("A.segments", 32'(ifa.segments), 32'(seg_ref(dig)));
            end else begin
                chk("B.tick", 32'(ifb.tick), 32'(m_tick[1]));
                chk("B.wrap", 32'(ifb.wrap), 32'(m_wrap[1]));
                chk("B.digit_sel", 32'(ifb.digit_sel), 32'(1) << idx);
                chk("B.segments", 32'(ifb.segments), 32'(seg_ref(dig)));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int c = 0;
        while (m_cnt[0] != target && c < budget) begin
            step();
            c++;
        end
        chk("cnt_budget", 32'(c >= budget), 32'd0);
    endtask

    task automatic run_until_pre_max(input int budget);
        int c = 0;
        while (m_pre[0] != A_MAX && c < budget) begin
            step();
            c++;
        end
        chk("pre_budget", 32'(c >= budget), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, then count up
        rst_n = 1'b0; en = 1'b0; ud = 1'b1; clr = 1'b0;
        run(2);
        chk("rst.digit_sel", 32'(ifa.digit_sel), 32'd1);
        chk("rst.segments", 32'(ifa.segments), 32'(seg_ref(0)));
        rst_n = 1'b1; en = 1'b1;
        run(40);

        // up to 98, then 99 and wrap to 00
        run_until_cnt(98, 600);
        run(8);

        // down from 00: 99 (wrap), 98; later 10 -> 09 borrow
        ud = 1'b0;
        run(8);
        run_until_cnt(10, 600);
        run(4);

        // freeze while scan keeps going, then resume
        run(2);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(10);

        // clear on a tick cycle
        run_until_pre_max(20);
        clr = 1'b1;
        step();
        clr = 1'b0;
        run(9);

        // reset mid-scan
        run(3);
        rst_n = 1'b0;
        step();
        chk("midrst.digit_sel", 32'(ifa.digit_sel), 32'd1);
        chk("midrst.segments", 32'(ifa.segments), 32'(seg_ref(0)));
        rst_n = 1'b1;
        run(12);

        // randomized soak
        for (int i = 0; i < 2500; i++) begin
            en    = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 19) == 0) ud = ~ud;
            clr   = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
